alu_share_arb: RTL and testbench

- Sequencer and round-robin arbiter that shares one combinational execute ALU between NUM_REQ requesters, e.g. the scalar pipeline and the matrix unit.
- Accepts an operation (opr_a, opr_b, alu_funct) over a valid/ready handshake and registers the operands onto the ALU inputs.
- Holds the operands stable for one cycle, or MUL_LATENCY cycles for OP_MUL, then captures the result.
- Returns the result to the owning requester over a valid/ready response handshake. One operation is in flight at a time.

---
 rtl/alu_share_arb.sv | 138 +++++++++++++
 tb/tb_alu_share_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin sequencer that time-shares one combinational execute ALU between
// NUM_REQ requesters, one operation in flight, result returned to its owner.
package alu_share_arb_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLTU = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;
endpackage

// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; req_valid_i must be held with stable operands until req_ready_o.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_opr_a_i,
  input  logic [NUM_REQ*32-1:0] req_opr_b_i,
  input  logic [NUM_REQ*4-1:0]  req_funct_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [31:0]           rsp_data_o,
  output logic [31:0]           alu_opr_a_o,
  output logic [31:0]           alu_opr_b_o,
  output logic [3:0]            alu_funct_o,
  input  logic [31:0]           alu_res_i,
  output logic                  busy_o,
  output logic [ID_W-1:0]       owner_o,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   win;
  logic              found;
  logic [ID_W:0]     idx_sum;
  logic [ID_W-1:0]   cand;
  logic [3:0]        win_funct;

  assign dbg_state = state;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    idx_sum = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx_sum >= (ID_W+1)'(NUM_REQ)) idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
      cand = idx_sum[ID_W-1:0];
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_funct = req_funct_i[{win, 2'd0} +: 4];

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (!reset && state == IDLE && found) req_ready_o[win] = 1'b1;
    if (!reset && state == RESP) rsp_valid_o[owner_o] = 1'b1;
  end

  assign busy_o = !reset && (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready_i[owner_o]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      owner_o     <= '0;
      alu_opr_a_o <= '0;
      alu_opr_b_o <= '0;
      alu_funct_o <= 4'h0;
      rsp_data_o  <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          alu_opr_a_o <= req_opr_a_i[{win, 5'd0} +: 32];
          alu_opr_b_o <= req_opr_b_i[{win, 5'd0} +: 32];
          alu_funct_o <= win_funct;
          owner_o     <= win;
          // Count holds the extra cycles a multiply needs its inputs stable.
          cnt         <= (win_funct == OP_MUL) ? CNT_W'(MUL_LATENCY-1) : '0;
        end
        EXEC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           rsp_data_o <= alu_res_i;
        end
        RESP: if (rsp_ready_i[owner_o]) begin
          rr_ptr <= (owner_o == ID_W'(NUM_REQ-1)) ? '0 : owner_o + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: per-requester op queues, a transaction-level model of
// arbitration and latency, and an expected-result queue for the responses.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int NR = 4;
  localparam int ML = 3;
  localparam int IW = $clog2(NR);
  localparam int DEPTH = 256;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic [31:0] e;
  } op_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*32-1:0]  req_a, req_b;
  logic [NR*4-1:0]   req_f;
  logic [31:0]       rsp_data, alu_a, alu_b, alu_res;
  logic [3:0]        alu_f;
  logic              busy;
  logic [IW-1:0]     owner;
  logic [1:0]        dbg_state;

  op_t         ops[NR][DEPTH];
  int          head[NR] = '{default: 0};
  int          tail[NR] = '{default: 0};
  logic [31:0] exp_q[$];
  int          grant_log[$];
  int          total = 0;
  int          bad = 0;
  int          rsp_mode = 0;
  bit          rand_gap = 1'b0;

  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_rr = 0, m_owner = 0, m_acc = 0, m_lat = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [3:0]  m_f = '0;

  alu_share_arb #(.NUM_REQ(NR), .MUL_LATENCY(ML)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opr_a_i(req_a), .req_opr_b_i(req_b), .req_funct_i(req_f),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .alu_opr_a_o(alu_a), .alu_opr_b_o(alu_b), .alu_funct_o(alu_f),
    .alu_res_i(alu_res), .busy_o(busy), .owner_o(owner), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] f);
    case (f)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_MUL:  return a * b;
      default: return a ^ b ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Stand-in for the shared execute ALU.
  always_comb alu_res = alu_ref(alu_a, alu_b, alu_f);

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic enq(int i, logic [31:0] a, logic [31:0] b, logic [3:0] f, logic [31:0] e);
    if (tail[i] < DEPTH) begin
      ops[i][tail[i]] = '{a: a, b: b, f: f, e: e};
      tail[i]++;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (head[i] < tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(int budget);
    int n = 0;
    while ((pending() || m_busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_timeout", (n >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic check_grants(string tag, int n, int g0, int g1, int g2, int g3);
    int g[4];
    g = '{g0, g1, g2, g3};
    check_eq({tag, "_count"}, grant_log.size(), n);
    for (int k = 0; k < n && k < grant_log.size(); k++) check_eq(tag, grant_log[k], g[k]);
    grant_log.delete();
  endtask

  // Requester and response-side driver: inputs change 1 time unit after the edge.
  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_f = '0; rsp_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (head[i] < tail[i] && (req_valid[i] || !rand_gap || $urandom_range(0, 2) != 0)) begin
          req_valid[i]       = 1'b1;
          req_a[32*i +: 32]  = ops[i][head[i]].a;
          req_b[32*i +: 32]  = ops[i][head[i]].b;
          req_f[4*i +: 4]    = ops[i][head[i]].f;
        end else begin
          req_valid[i] = 1'b0;
        end
        case (rsp_mode)
          0:       rsp_ready[i] = 1'b1;
          1:       rsp_ready[i] = 1'($urandom_range(0, 1));
          default: rsp_ready[i] = 1'b0;
        endcase
      end
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_rv;
    int w;
    cyc++;
    if (reset) begin
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_owner", 32'(owner), 32'd0);
      check_eq("rst_alu_a", alu_a, 32'd0);
      check_eq("rst_alu_b", alu_b, 32'd0);
      check_eq("rst_alu_f", 32'(alu_f), 32'd0);
      check_eq("rst_rsp_data", rsp_data, 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'd0);
      m_busy = 1'b0; m_rr = 0; m_owner = 0;
      m_a = '0; m_b = '0; m_f = '0;
      exp_q.delete();
    end else begin
      exp_rdy = '0;
      w = -1;
      if (!m_busy)
        for (int k = 0; k < NR; k++)
          if (w < 0 && req_valid[(m_rr + k) % NR]) w = (m_rr + k) % NR;
      if (w >= 0) exp_rdy[w] = 1'b1;
      exp_rv = '0;
      if (m_busy && cyc >= m_acc + m_lat) exp_rv[m_owner] = 1'b1;
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("owner", 32'(owner), m_owner);
      check_eq("alu_a", alu_a, m_a);
      check_eq("alu_b", alu_b, m_b);
      check_eq("alu_f", 32'(alu_f), 32'(m_f));
      if (exp_rv != '0) begin
        if (exp_q.size() > 0) check_eq("rsp_data", rsp_data, exp_q[0]);
        if (rsp_ready[m_owner]) begin
          void'(exp_q.pop_front());
          m_busy = 1'b0;
          m_rr   = (m_owner + 1) % NR;
        end
      end else if (w >= 0) begin
        m_busy  = 1'b1;
        m_acc   = cyc;
        m_owner = w;
        m_a     = ops[w][head[w]].a;
        m_b     = ops[w][head[w]].b;
        m_f     = ops[w][head[w]].f;
        m_lat   = (m_f == OP_MUL) ? 1 + ML : 2;
        exp_q.push_back(ops[w][head[w]].e);
        grant_log.push_back(w);
        head[w]++;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);

    // Single ADD from requester 0.
    enq(0, 32'h5, 32'h3, OP_ADD, 32'h8);
    wait_idle(50);
    check_grants("grant_add", 1, 0, 0, 0, 0);

    // Multiply on requester 1 holds the ALU inputs for ML cycles.
    enq(1, 32'h1234, 32'h10, OP_MUL, 32'h12340);
    wait_idle(50);
    check_grants("grant_mul", 1, 1, 0, 0, 0);

    // Pointer now at 2: requester 3 beats requester 1, then 1 follows.
    enq(3, 32'd100, 32'd23, OP_ADD, 32'd123);
    enq(1, 32'hFF00_FF00, 32'h0F0F_0F0F, OP_AND, 32'h0F00_0F00);
    wait_idle(80);
    check_grants("grant_skip", 2, 3, 1, 0, 0);

    // Response backpressure with a competing request waiting.
    rsp_mode = 2;
    enq(2, 32'hF0F0_0000, 32'h0FF0_00FF, OP_XOR, 32'hFF00_00FF);
    enq(3, 32'h1, 32'h2, OP_OR, 32'h3);
    n = 0;
    while (!(m_busy && cyc >= m_acc + m_lat) && n < 20) begin
      @(posedge clk);
      n++;
    end
    check_eq("bp_reach_resp", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    repeat (5) @(posedge clk);
    rsp_mode = 0;
    wait_idle(80);
    check_grants("grant_bp", 2, 2, 3, 0, 0);

    // Both requesters continuously valid with SUB: strict alternation.
    enq(0, 32'd10, 32'd4, OP_SUB, 32'h6);
    enq(0, 32'd10, 32'd4, OP_SUB, 32'h6);
    enq(1, 32'd7, 32'd9, OP_SUB, 32'hFFFF_FFFE);
    enq(1, 32'd7, 32'd9, OP_SUB, 32'hFFFF_FFFE);
    wait_idle(80);
    check_grants("grant_alt", 4, 0, 1, 0, 1);

    // Reset during EXEC aborts the op; arbitration restarts from index 0.
    enq(1, 32'hFFFF_FFFF, 32'h1, OP_SLT, 32'h1);
    n = 0;
    while (!m_busy && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    check_grants("grant_abort", 1, 1, 0, 0, 0);
    enq(1, 32'd3, 32'd1, OP_SLL, 32'd6);
    enq(0, 32'h8000_0000, 32'd4, OP_SRA, 32'hF800_0000);
    wait_idle(80);
    check_grants("grant_post_rst", 2, 0, 1, 0, 0);

    // Random traffic with gaps and random response backpressure.
    rand_gap = 1'b1;
    rsp_mode = 1;
    for (int t = 0; t < 120; t++) begin
      logic [31:0] a, b;
      logic [3:0]  f;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      f = ($urandom_range(0, 3) == 0) ? OP_MUL : 4'($urandom_range(0, 15));
      enq($urandom_range(0, NR - 1), a, b, f, alu_ref(a, b, f));
    end
    wait_idle(5000);
    grant_log.delete();
    check_eq("exp_q_empty", exp_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
